// File: rtl/ysyx_041514_pipe_stage.sv
// ysyx_041514_pipe_stage: valid/ready pipeline register with optional 2-entry skid buffer.
// Flush and empty slots present RESET_VAL so downstream can decode them as a NOP.
module ysyx_041514_pipe_stage #(
    parameter int          WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit          SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] skid, skid_nx, data_nx;
    logic             ready_q, in_fire, out_fire;

    assign out_valid_o = state != EMPTY;
    assign count_o     = state;
    assign in_ready_o  = SKID ? ready_q : (!out_valid_o || out_ready_i);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        state_nx = state;
        data_nx  = out_data_o;
        skid_nx  = skid;
        if (flush_i) begin
            state_nx = EMPTY;
            data_nx  = RESET_VAL;
            skid_nx  = RESET_VAL;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = ONE;
                    data_nx  = in_data_i;
                end
                ONE: if (in_fire && out_fire) begin
                    data_nx = in_data_i;
                end else if (in_fire) begin
                    // Only reachable with SKID=1: without skid, in_fire in ONE implies out_fire
                    state_nx = FULL;
                    skid_nx  = in_data_i;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                    data_nx  = RESET_VAL;
                end
                FULL: if (out_fire) begin
                    state_nx = ONE;
                    data_nx  = skid;
                    skid_nx  = RESET_VAL;
                end
                default: begin
                    state_nx = EMPTY;
                    data_nx  = RESET_VAL;
                    skid_nx  = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            out_data_o <= RESET_VAL;
            skid       <= RESET_VAL;
            ready_q    <= 1'b1;
        end else begin
            state      <= state_nx;
            out_data_o <= data_nx;
            skid       <= skid_nx;
            ready_q    <= state_nx != FULL;
        end
    end
endmodule

// File: tb/tb_ysyx_041514_pipe_stage.sv
// tb_ysyx_041514_pipe_stage: directed checks of the skid (SKID=1) and plain (SKID=0) stage.
module tb_ysyx_041514_pipe_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b0;
    logic        flush, in_valid, out_ready, flush0, in_valid0, out_ready0;
    logic [31:0] in_data, in_data0;
    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [31:0] out_data, out_data0;
    logic [1:0]  count, count0;
    int          checks = 0, passed = 0;

    always #5 clk = ~clk;

    ysyx_041514_pipe_stage #(.WIDTH(32), .RESET_VAL(NOP), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .count_o(count)
    );

    ysyx_041514_pipe_stage #(.WIDTH(32), .RESET_VAL(NOP), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush0),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
        .count_o(count0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".data"}, out_data, d);
        check({tag, ".count"}, {30'd0, count}, {30'd0, c});
        check({tag, ".ready"}, {31'd0, in_ready}, {31'd0, r});
    endtask

    task automatic expect0(input string tag, input logic v, input logic [31:0] d, input logic r);
        check({tag, ".valid"}, {31'd0, out_valid0}, {31'd0, v});
        check({tag, ".data"}, out_data0, d);
        check({tag, ".count"}, {30'd0, count0}, {31'd0, v});
        check({tag, ".ready"}, {31'd0, in_ready0}, {31'd0, r});
    endtask

    initial begin
        flush = 0; in_valid = 0; out_ready = 0; in_data = 0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = 0;
        #12 rst = 1'b1;
        step();
        expect1("reset", 0, NOP, 0, 1);
        expect0("reset0", 0, NOP, 1);

        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            step();
            expect1($sformatf("stream%0d", i), 1, i, 1, 1);
        end
        in_valid = 0;
        step();
        expect1("drain", 0, NOP, 0, 1);

        out_ready = 0; in_valid = 1; in_data = 32'hA;
        step();
        expect1("bp_a", 1, 32'hA, 1, 1);
        in_data = 32'hB;
        step();
        expect1("bp_full", 1, 32'hA, 2, 0);
        in_data = 32'hC;
        step();
        expect1("bp_hold", 1, 32'hA, 2, 0);
        out_ready = 1;
        step();
        expect1("bp_b", 1, 32'hB, 1, 1);
        step();
        expect1("bp_c", 1, 32'hC, 1, 1);
        in_valid = 0;
        step();
        expect1("bp_empty", 0, NOP, 0, 1);

        out_ready = 0; in_valid = 1; in_data = 32'h5;
        step();
        in_data = 32'h6;
        step();
        expect1("fl_full", 1, 32'h5, 2, 0);
        flush = 1; in_data = 32'h7;
        step();
        expect1("flush", 0, NOP, 0, 1);
        flush = 0; in_valid = 0; out_ready = 1;
        step();
        expect1("flush_after", 0, NOP, 0, 1);

        out_ready = 0; in_valid = 1; in_data = 32'h8;
        step();
        in_data = 32'h9;
        step();
        expect1("ar_full", 1, 32'h8, 2, 0);
        in_valid = 0;
        #2 rst = 1'b0;
        #1 expect1("async_rst", 0, NOP, 0, 1);
        #1 rst = 1'b1;
        step();
        expect1("post_rst", 0, NOP, 0, 1);

        in_valid0 = 1; out_ready0 = 1; in_data0 = 32'h21;
        #1 check("s0_ready_empty", {31'd0, in_ready0}, 32'd1);
        step();
        expect0("s0_load", 1, 32'h21, 1);
        out_ready0 = 0; in_data0 = 32'h22;
        #1 expect0("s0_stall", 1, 32'h21, 0);
        step();
        expect0("s0_held", 1, 32'h21, 0);
        out_ready0 = 1;
        #1 check("s0_ready_back", {31'd0, in_ready0}, 32'd1);
        step();
        expect0("s0_next", 1, 32'h22, 1);
        in_valid0 = 0;
        step();
        expect0("s0_drain", 0, NOP, 1);
        in_valid0 = 1; in_data0 = 32'h23;
        step();
        flush0 = 1; in_data0 = 32'h24;
        step();
        expect0("s0_flush", 0, NOP, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
